// File: rtl/fifo_rd_ctrl.sv
// fifo_rd_ctrl: read-side pointer, empty/count flags and memory control for an async FIFO.
module fifo_rd_ctrl #(
  parameter int ADDR_WIDTH = 3,
  parameter int AE_LEVEL   = 1,
  localparam int PW        = ADDR_WIDTH + 1
) (
  input  logic                  rclk,
  input  logic                  rrst_n,
  input  logic                  rinc,
  input  logic [PW-1:0]         rq2_wptr,
  output logic                  rempty,
  output logic [PW-1:0]         rptr,
  output logic [ADDR_WIDTH-1:0] raddr,
  output logic                  rclken,
  output logic                  rvalid,
  output logic [PW-1:0]         rcount,
  output logic                  ralmost_empty,
  output logic                  runderflow
);
  logic [PW-1:0] bn_rptr_q, bn_rptr_d, rptr_q, rptr_d, rcount_q, rcount_d, wbin;
  logic          rvalid_q, rvalid_d, runderflow_q, runderflow_d;
  always_comb begin
    wbin = '0;
    for (int i = 0; i < PW; i++) wbin[i] = ^(rq2_wptr >> i);
  end
  assign rempty        = rptr_q == rq2_wptr;
  assign rclken        = rinc & ~rempty;
  assign raddr         = bn_rptr_q[ADDR_WIDTH-1:0];
  assign rptr          = rptr_q;
  assign rvalid        = rvalid_q;
  assign rcount        = rcount_q;
  assign runderflow    = runderflow_q;
  assign ralmost_empty = rcount_q <= PW'(AE_LEVEL);
  // rptr is registered from the next binary value so it only ever moves one Gray step
  always_comb begin
    bn_rptr_d    = bn_rptr_q + PW'(rclken);
    rptr_d       = bn_rptr_d ^ (bn_rptr_d >> 1);
    rcount_d     = wbin - bn_rptr_q;
    rvalid_d     = rclken;
    runderflow_d = runderflow_q | (rinc & rempty);
  end
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      bn_rptr_q    <= '0;
      rptr_q       <= '0;
      rcount_q     <= '0;
      rvalid_q     <= 1'b0;
      runderflow_q <= 1'b0;
    end else begin
      bn_rptr_q    <= bn_rptr_d;
      rptr_q       <= rptr_d;
      rcount_q     <= rcount_d;
      rvalid_q     <= rvalid_d;
      runderflow_q <= runderflow_d;
    end
  end
endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// tb_fifo_rd_ctrl: directed bench for fifo_rd_ctrl with hand-computed Gray/count expectations.
module tb_fifo_rd_ctrl;
  logic       rclk = 1'b0, rrst_n = 1'b0, rinc = 1'b0;
  logic [3:0] rq2_wptr = '0;
  logic       rempty, rclken, rvalid, ralmost_empty, runderflow;
  logic [3:0] rptr, rcount;
  logic [2:0] raddr;
  int         vecs = 0, errs = 0;
  logic [3:0] bn, wb;

  fifo_rd_ctrl #(.ADDR_WIDTH(3), .AE_LEVEL(1)) dut (
    .rclk(rclk), .rrst_n(rrst_n), .rinc(rinc), .rq2_wptr(rq2_wptr),
    .rempty(rempty), .rptr(rptr), .raddr(raddr), .rclken(rclken),
    .rvalid(rvalid), .rcount(rcount), .ralmost_empty(ralmost_empty),
    .runderflow(runderflow)
  );

  always #5 rclk = ~rclk;

  function automatic logic [3:0] gray(input logic [3:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    // reset with empty write pointer
    repeat (2) @(negedge rclk);
    rrst_n = 1'b1;
    #1;
    chk("rst_rempty", 32'(rempty), 1);
    chk("rst_rptr", 32'(rptr), 0);
    chk("rst_raddr", 32'(raddr), 0);
    chk("rst_rcount", 32'(rcount), 0);
    chk("rst_ae", 32'(ralmost_empty), 1);
    chk("rst_uflow", 32'(runderflow), 0);
    chk("rst_rclken", 32'(rclken), 0);
    chk("rst_rvalid", 32'(rvalid), 0);
    // four entries written, no read
    @(negedge rclk);
    rq2_wptr = 4'b0110;
    #1;
    chk("w4_rempty", 32'(rempty), 0);
    @(negedge rclk);
    chk("w4_rcount", 32'(rcount), 4);
    chk("w4_ae", 32'(ralmost_empty), 0);
    // drain four entries
    rinc = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("drain_raddr", 32'(raddr), 32'(k));
      chk("drain_rclken", 32'(rclken), 1);
      @(negedge rclk);
      chk("drain_rptr", 32'(rptr), 32'(gray(4'(k + 1))));
      chk("drain_rvalid", 32'(rvalid), 1);
    end
    rinc = 1'b0;
    chk("drain_rempty", 32'(rempty), 1);
    chk("drain_rptr4", 32'(rptr), 32'h6);
    chk("drain_rcount_lag", 32'(rcount), 1);
    chk("drain_ae", 32'(ralmost_empty), 1);
    @(negedge rclk);
    chk("drain_rvalid_off", 32'(rvalid), 0);
    chk("drain_rcount0", 32'(rcount), 0);
    chk("drain_uflow", 32'(runderflow), 0);
    // 16 reads with the writer three entries ahead; raddr wraps twice
    bn = 4'd4;
    for (int k = 0; k < 16; k++) begin
      wb = bn + 4'd3;
      rq2_wptr = gray(wb);
      rinc = 1'b1;
      #1;
      chk("wrap_rempty", 32'(rempty), 0);
      chk("wrap_raddr", 32'(raddr), 32'(bn[2:0]));
      @(negedge rclk);
      bn = bn + 4'd1;
      chk("wrap_rptr", 32'(rptr), 32'(gray(bn)));
      chk("wrap_rcount", 32'(rcount), 3);
    end
    rinc = 1'b0;
    chk("wrap_rptr_back", 32'(rptr), 32'h6);
    rq2_wptr = gray(bn);
    #1;
    chk("wrap_empty", 32'(rempty), 1);
    // read while empty
    @(negedge rclk);
    rinc = 1'b1;
    #1;
    chk("uf_rclken", 32'(rclken), 0);
    chk("uf_raddr", 32'(raddr), 4);
    @(negedge rclk);
    rinc = 1'b0;
    chk("uf_rptr", 32'(rptr), 32'h6);
    chk("uf_rvalid", 32'(rvalid), 0);
    chk("uf_set", 32'(runderflow), 1);
    @(negedge rclk);
    chk("uf_held", 32'(runderflow), 1);
    chk("uf_raddr_hold", 32'(raddr), 4);
    // three reads then an asynchronous reset pulse between edges
    rq2_wptr = gray(4'd8);
    rinc = 1'b1;
    repeat (3) @(negedge rclk);
    rinc = 1'b0;
    chk("pre_rst_rptr", 32'(rptr), 32'(gray(4'd7)));
    #1;
    rrst_n = 1'b0;
    #1;
    chk("arst_rptr", 32'(rptr), 0);
    chk("arst_rcount", 32'(rcount), 0);
    chk("arst_uflow", 32'(runderflow), 0);
    chk("arst_rvalid", 32'(rvalid), 0);
    chk("arst_raddr", 32'(raddr), 0);
    #1;
    rrst_n = 1'b1;
    // first read after reset starts at address 0; FIFO appears full
    @(negedge rclk);
    rinc = 1'b1;
    #1;
    chk("post_raddr", 32'(raddr), 0);
    chk("post_rclken", 32'(rclken), 1);
    @(negedge rclk);
    rinc = 1'b0;
    chk("post_rptr", 32'(rptr), 1);
    chk("post_rcount_full", 32'(rcount), 8);
    chk("post_uflow", 32'(runderflow), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
